// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared address map and STATUS bit positions for io_ctrl.
// Revision : 1.0
// ============================================================================
package io_pkg;

  localparam logic [2:0] ADDR_OUT0   = 3'd0;
  localparam logic [2:0] ADDR_OUT1   = 3'd1;
  localparam logic [2:0] ADDR_IN0    = 3'd2;
  localparam logic [2:0] ADDR_TXDATA = 3'd3;
  localparam logic [2:0] ADDR_RXDATA = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_TIMER  = 3'd6;
  localparam logic [2:0] ADDR_RSVD   = 3'd7;

  // Ordering chosen so the post-reset STATUS value reads 0x0005.
  localparam int STAT_TX_EMPTY   = 0;
  localparam int STAT_RX_FULL    = 1;
  localparam int STAT_RX_EMPTY   = 2;
  localparam int STAT_TIMER_DONE = 3;
  localparam int STAT_TX_OVF     = 4;
  localparam int STAT_RX_CNT_LSB = 5;

endpackage
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync
// Purpose  : Single-clock FIFO; push into a full FIFO is accepted when a pop
//            retires an entry in the same cycle.
// Revision : 1.0
// ============================================================================
module fifo_sync #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once the count covers it.
  always_ff @(posedge clk) begin
    if (reset && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : io_ctrl
// Purpose  : CPU-mapped I/O block: GPIO registers, TX/RX stream FIFOs,
//            one-shot down-counter and interrupt.
// Revision : 1.0
// ============================================================================
module io_ctrl
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Direcciones,
  input  logic [15:0] wdata,
  input  logic        oe,
  input  logic        rd,
  output logic [15:0] rdata,
  output logic [15:0] out_port0,
  output logic [15:0] out_port1,
  input  logic [15:0] in_port0,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   out0_q, out0_d, out1_q, out1_d;
  logic [15:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0]   timer_q, timer_d;
  logic          timer_done_q, timer_done_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          hit, wr_en, rd_en;
  logic [2:0]    addr;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [15:0]   rx_head;
  logic [3:0]    rx_cnt_nib;
  logic [15:0]   status;

  assign addr  = Direcciones[2:0];
  assign hit   = (Direcciones[15:3] == 13'd0);
  assign wr_en = oe && hit;
  assign rd_en = rd && !oe && hit;

  // Handshakes are masked while reset is low so nothing transfers that cycle.
  assign tx_valid = reset && (tx_count != '0);
  assign rx_ready = reset && !rx_full;
  assign tx_push  = wr_en && (addr == ADDR_TXDATA);
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_en && (addr == ADDR_RXDATA);

  fifo_sync #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (wdata),
    .pop       (tx_pop),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  fifo_sync #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  generate
    if (CW >= 4) begin : g_nib_trunc
      assign rx_cnt_nib = rx_count[3:0];
    end else begin : g_nib_ext
      assign rx_cnt_nib = {{(4 - CW){1'b0}}, rx_count};
    end
  endgenerate

  always_comb begin
    status                          = '0;
    status[STAT_TX_EMPTY]           = tx_empty;
    status[STAT_RX_FULL]            = rx_full;
    status[STAT_RX_EMPTY]           = rx_empty;
    status[STAT_TIMER_DONE]         = timer_done_q;
    status[STAT_TX_OVF]             = tx_ovf_q;
    status[STAT_RX_CNT_LSB +: 4]    = rx_cnt_nib;
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (addr)
        ADDR_OUT0:              rdata = out0_q;
        ADDR_OUT1:              rdata = out1_q;
        ADDR_IN0:               rdata = sync2_q;
        ADDR_RXDATA:            rdata = rx_empty ? 16'h0000 : rx_head;
        ADDR_STATUS:            rdata = status;
        ADDR_TIMER:             rdata = timer_q;
        ADDR_TXDATA, ADDR_RSVD: rdata = '0;
        default:                rdata = '0;
      endcase
    end
  end

  always_comb begin
    out0_d       = out0_q;
    out1_d       = out1_q;
    sync1_d      = in_port0;
    sync2_d      = sync1_q;
    timer_d      = timer_q;
    timer_done_d = timer_done_q;
    tx_ovf_d     = tx_ovf_q;
    if (wr_en && addr == ADDR_OUT0) out0_d = wdata;
    if (wr_en && addr == ADDR_OUT1) out1_d = wdata;
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rd_en && addr == ADDR_STATUS) tx_ovf_d = 1'b0;
    if (wr_en && addr == ADDR_TIMER) begin
      timer_d      = wdata;
      timer_done_d = 1'b0;
    end else if (timer_q != 16'd0) begin
      timer_d = timer_q - 16'd1;
      if (timer_q == 16'd1) timer_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out0_q       <= '0;
      out1_q       <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      timer_q      <= '0;
      timer_done_q <= 1'b0;
      tx_ovf_q     <= 1'b0;
    end else begin
      out0_q       <= out0_d;
      out1_q       <= out1_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      timer_q      <= timer_d;
      timer_done_q <= timer_done_d;
      tx_ovf_q     <= tx_ovf_d;
    end
  end

  assign out_port0 = out0_q;
  assign out_port1 = out1_q;
  assign irq       = timer_done_q || !rx_empty;

endmodule
`default_nettype wire

// File: tb/tb_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_ctrl
// Purpose  : Self-checking bench for io_ctrl: directed tables plus random
//            traffic against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_io_ctrl;

  localparam int D = 4;

  logic        clk;
  logic        reset;
  logic [15:0] Direcciones, wdata, rdata, out_port0, out_port1, in_port0;
  logic        oe, rd;
  logic [15:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  int checks   = 0;
  int failures = 0;

  io_ctrl #(.FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .Direcciones (Direcciones),
    .wdata       (wdata),
    .oe          (oe),
    .rd          (rd),
    .rdata       (rdata),
    .out_port0   (out_port0),
    .out_port1   (out_port1),
    .in_port0    (in_port0),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [15:0] m_out0 = 0, m_out1 = 0, m_s1 = 0, m_s2 = 0;
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic        m_ovf = 0, m_done = 0;
  int          m_timer = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_tx_valid();
    return reset && (tx_q.size() != 0);
  endfunction

  function automatic logic exp_rx_ready();
    return reset && (rx_q.size() < D);
  endfunction

  function automatic logic [15:0] exp_status();
    int n = rx_q.size();
    return 16'((n % 16) * 32) + 16'(m_ovf) * 16'd16 + 16'(m_done) * 16'd8
         + 16'(n == 0) * 16'd4 + 16'(n == D) * 16'd2 + 16'(tx_q.size() == 0);
  endfunction

  function automatic logic [15:0] exp_rdata();
    if (Direcciones[15:3] != 13'd0) return 16'h0000;
    case (Direcciones[2:0])
      3'd0:    return m_out0;
      3'd1:    return m_out1;
      3'd2:    return m_s2;
      3'd4:    return (rx_q.size() != 0) ? rx_q[0] : 16'h0000;
      3'd5:    return exp_status();
      3'd6:    return 16'(m_timer);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_compare();
    logic txv;
    txv = exp_tx_valid();
    chk("m_rdata", rdata, exp_rdata());
    chk("m_tx_valid", 16'(tx_valid), 16'(txv));
    if (txv) chk("m_tx_data", tx_data, tx_q[0]);
    chk("m_rx_ready", 16'(rx_ready), 16'(exp_rx_ready()));
    chk("m_irq", 16'(irq), 16'(m_done || (rx_q.size() != 0)));
    chk("m_out0", out_port0, m_out0);
    chk("m_out1", out_port1, m_out1);
  endtask

  task automatic model_step();
    logic       txv, rxr, hit, wr, rdv;
    logic [2:0] a;
    txv = exp_tx_valid();
    rxr = exp_rx_ready();
    if (!reset) begin
      m_out0 = 0; m_out1 = 0; m_s1 = 0; m_s2 = 0;
      m_ovf = 0; m_done = 0; m_timer = 0;
      tx_q.delete();
      rx_q.delete();
      return;
    end
    hit = (Direcciones[15:3] == 13'd0);
    a   = Direcciones[2:0];
    wr  = oe && hit;
    rdv = rd && !oe && hit;
    if (txv && tx_ready) void'(tx_q.pop_front());
    if (wr && a == 3'd3) begin
      if (tx_q.size() < D) tx_q.push_back(wdata);
      else m_ovf = 1;
    end
    if (rdv && a == 3'd4 && rx_q.size() != 0) void'(rx_q.pop_front());
    if (rx_valid && rxr) rx_q.push_back(rx_data);
    if (rdv && a == 3'd5) m_ovf = 0;
    if (wr && a == 3'd6) begin
      m_timer = int'(wdata);
      m_done  = 0;
    end else if (m_timer > 0) begin
      m_timer--;
      if (m_timer == 0) m_done = 1;
    end
    if (wr && a == 3'd0) m_out0 = wdata;
    if (wr && a == 3'd1) m_out1 = wdata;
    m_s2 = m_s1;
    m_s1 = in_port0;
  endtask

  task automatic settle();
    @(negedge clk);
    model_compare();
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
    Direcciones = a; wdata = d; oe = w; rd = r;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        oe;
    logic        rd;
    logic [15:0] exp_rdata;
    logic [15:0] exp_out0;
    logic [15:0] exp_out1;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{16'h0000, 16'h00A5, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h00A5, 16'h00A5, 16'h0000});
    vecs.push_back('{16'h0001, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 16'h00A5, 16'h0000});
    vecs.push_back('{16'h0001, 16'h0000, 1'b0, 1'b1, 16'h5A5A, 16'h00A5, 16'h5A5A});
    vecs.push_back('{16'h0007, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 16'h00A5, 16'h5A5A});
    vecs.push_back('{16'h0007, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h00A5, 16'h5A5A});
    vecs.push_back('{16'h0008, 16'h1234, 1'b1, 1'b0, 16'h0000, 16'h00A5, 16'h5A5A});
    vecs.push_back('{16'h0008, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h00A5, 16'h5A5A});
    vecs.push_back('{16'h8001, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 16'h00A5, 16'h5A5A});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h00A5, 16'h00A5, 16'h5A5A});
    vecs.push_back('{16'h0001, 16'h0000, 1'b0, 1'b1, 16'h5A5A, 16'h00A5, 16'h5A5A});
    vecs.push_back('{16'h0005, 16'h0000, 1'b0, 1'b1, 16'h0005, 16'h00A5, 16'h5A5A});
    vecs.push_back('{16'h0006, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h00A5, 16'h5A5A});
    vecs.push_back('{16'h0003, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h00A5, 16'h5A5A});
    vecs.push_back('{16'h0002, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h00A5, 16'h5A5A});

    reset = 1'b0; in_port0 = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
    bus(16'h0007, 16'h0000, 1'b0, 1'b0);
    settle(); adv();
    settle(); adv();
    reset = 1'b1;

    // Post-reset state
    bus(16'h0005, 16'h0000, 1'b0, 1'b1);
    settle();
    chk("rst_out0", out_port0, 16'h0000);
    chk("rst_tx_valid", 16'(tx_valid), 16'h0000);
    chk("rst_rx_ready", 16'(rx_ready), 16'h0001);
    chk("rst_irq", 16'(irq), 16'h0000);
    chk("rst_status", rdata, 16'h0005);
    adv();
    bus(16'h0007, 16'h0000, 1'b0, 1'b0);
    settle();
    chk("rst_unmapped", rdata, 16'h0000);
    adv();

    // Register map table
    foreach (vecs[i]) begin
      bus(vecs[i].addr, vecs[i].wdata, vecs[i].oe, vecs[i].rd);
      settle();
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_out0", i), out_port0, vecs[i].exp_out0);
      chk($sformatf("vec%0d_out1", i), out_port1, vecs[i].exp_out1);
      adv();
    end

    // Input synchronizer latency
    in_port0 = 16'h1234;
    bus(16'h0002, 16'h0000, 1'b0, 1'b1);
    settle(); chk("in0_lat0", rdata, 16'h0000); adv();
    settle(); chk("in0_lat1", rdata, 16'h0000); adv();
    settle(); chk("in0_lat2", rdata, 16'h1234); adv();

    // TX overflow, sticky flag cleared by STATUS read, then drain in order
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus(16'h0003, 16'h1001 + 16'(i), 1'b1, 1'b0);
      settle(); adv();
    end
    bus(16'h0005, 16'h0000, 1'b0, 1'b1);
    settle();
    chk("tx_ovf_status", rdata, 16'h0014);
    chk("tx_head", tx_data, 16'h1001);
    adv();
    settle(); chk("tx_ovf_cleared", rdata, 16'h0004); adv();
    bus(16'h0007, 16'h0000, 1'b0, 1'b0);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("tx_drain_valid", 16'(tx_valid), 16'h0001);
      chk("tx_drain_data", tx_data, 16'h1001 + 16'(i));
      adv();
    end
    settle(); chk("tx_drained", 16'(tx_valid), 16'h0000); adv();
    tx_ready = 1'b0;

    // RX fill, pop with concurrent rx_valid, pop on empty
    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 16'h2001 + 16'(i);
      settle(); adv();
    end
    rx_valid = 1'b0;
    bus(16'h0005, 16'h0000, 1'b0, 1'b1);
    settle();
    chk("rx_full_ready", 16'(rx_ready), 16'h0000);
    chk("rx_full_irq", 16'(irq), 16'h0001);
    chk("rx_full_status", rdata, 16'h0083);
    adv();
    bus(16'h0004, 16'h0000, 1'b0, 1'b1);
    rx_valid = 1'b1; rx_data = 16'h2005;
    settle(); chk("rx_pop_full", rdata, 16'h2001); adv();
    rx_data = 16'h2006;
    settle();
    chk("rx_pp_ready", 16'(rx_ready), 16'h0001);
    chk("rx_pp_data", rdata, 16'h2002);
    adv();
    rx_valid = 1'b0;
    bus(16'h0005, 16'h0000, 1'b0, 1'b1);
    settle(); chk("rx_pp_count", rdata, 16'h0061); adv();
    bus(16'h0004, 16'h0000, 1'b0, 1'b1);
    settle(); chk("rx_pop3", rdata, 16'h2003); adv();
    settle(); chk("rx_pop4", rdata, 16'h2004); adv();
    settle(); chk("rx_pop5", rdata, 16'h2006); adv();
    settle();
    chk("rx_pop_empty", rdata, 16'h0000);
    chk("rx_empty_irq", 16'(irq), 16'h0000);
    adv();
    bus(16'h0005, 16'h0000, 1'b0, 1'b1);
    settle(); chk("rx_empty_status", rdata, 16'h0005); adv();

    // Timer: load 3, done exactly 3 edges later; load 0 never completes
    bus(16'h0006, 16'h0003, 1'b1, 1'b0);
    settle(); adv();
    bus(16'h0006, 16'h0000, 1'b0, 1'b1);
    for (int i = 3; i > 0; i--) begin
      settle();
      chk("tmr_count", rdata, 16'(i));
      chk("tmr_irq_low", 16'(irq), 16'h0000);
      adv();
    end
    settle();
    chk("tmr_irq", 16'(irq), 16'h0001);
    chk("tmr_zero", rdata, 16'h0000);
    adv();
    bus(16'h0005, 16'h0000, 1'b0, 1'b1);
    settle(); chk("tmr_status", rdata, 16'h000D); adv();
    bus(16'h0006, 16'h0000, 1'b1, 1'b0);
    settle(); adv();
    bus(16'h0005, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("tmr0_irq", 16'(irq), 16'h0000);
      chk("tmr0_status", rdata, 16'h0005);
      adv();
    end

    // Reset in the middle of a TX transfer
    for (int i = 0; i < 2; i++) begin
      bus(16'h0003, 16'h3001 + 16'(i), 1'b1, 1'b0);
      settle(); adv();
    end
    bus(16'h0007, 16'h0000, 1'b0, 1'b0);
    tx_ready = 1'b1;
    reset = 1'b0;
    settle(); chk("midrst_tx_valid", 16'(tx_valid), 16'h0000); adv();
    reset = 1'b1;
    bus(16'h0005, 16'h0000, 1'b0, 1'b1);
    settle();
    chk("midrst_after_valid", 16'(tx_valid), 16'h0000);
    chk("midrst_status", rdata, 16'h0005);
    chk("midrst_out0", out_port0, 16'h0000);
    adv();

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a;
      logic [15:0] d;
      a = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
      d = 16'($urandom);
      if (a == 16'h0006 && $urandom_range(0, 1) == 1) d = 16'($urandom_range(0, 8));
      bus(a, d, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      tx_ready = ($urandom_range(0, 1) == 1);
      rx_valid = ($urandom_range(0, 1) == 1);
      rx_data  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) in_port0 = 16'($urandom);
      reset = ($urandom_range(0, 199) != 0);
      settle(); adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
